// File: rtl/rv_types.sv
// Shared types, register offsets and FSM state encodings for the rv_sio UART.
package rv_types;

    typedef logic [3:0]  u4_t;
    typedef logic [7:0]  u8_t;
    typedef logic [31:0] u32_t;

    localparam logic [4:0] ADR_DATA = 5'h00;
    localparam logic [4:0] ADR_STAT = 5'h04;
    localparam logic [4:0] ADR_CTRL = 5'h08;
    localparam logic [4:0] ADR_BAUD = 5'h0C;

    typedef enum logic {
        TX_IDLE,
        TX_RUN
    } tx_st_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_st_e;

endpackage

// File: rtl/sio_fifo.sv
// Synchronous byte FIFO with full/empty flags; DEPTH=1 acts as a holding register.
module sio_fifo
    import rv_types::*;
#(
    parameter int DEPTH = 16
) (
    input  logic clk,
    input  logic xreset,
    input  logic push,
    input  u8_t  din,
    input  logic pop,
    output u8_t  dout,
    output logic full,
    output logic empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    u8_t           mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_pop  = pop & ~empty;
    // a pop in the same cycle frees the slot a full FIFO needs for the push
    assign do_push = push & (~full | do_pop);
    assign dout    = mem_q[rp_q];

    always_comb begin
        wp_d  = do_push ? inc(wp_q) : wp_q;
        rp_d  = do_pop ? inc(rp_q) : rp_q;
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (xreset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q] <= din;
    end

endmodule

// File: rtl/rv_sio.sv
// 8N1 UART with bus register window; define RV_SIO_FIFO_EN for FIFO_DEPTH-entry
// TX/RX FIFOs, otherwise single-byte holding registers.
module rv_sio
    import rv_types::*;
#(
    parameter int DIV_RST    = 867,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        xreset,
    input  logic [4:0]  adr,
    input  logic        cs,
    input  logic        rdy,
    input  logic [3:0]  we,
    input  logic        re,
    input  logic [31:0] dw,
    output logic [31:0] dr,
    output logic        irq,
    input  logic        rxd,
    output logic        txd,
    input  logic        dsr,
    output logic        dtr,
    output logic        txen
);

`ifdef RV_SIO_FIFO_EN
    localparam int DEPTH = FIFO_DEPTH;
`else
    localparam int DEPTH = 1;
`endif

    logic        acc, rd_en, clr_ovr, clr_ferr;
    logic        tx_push, tx_pop, tx_full, tx_empty, tx_go;
    logic        rx_pop, rx_full, rx_empty, rx_done, rx_ferr;
    u8_t         tx_dout, rx_dout;
    u32_t        rdata;
    logic        unused_ok;

    logic [2:0]  ctrl_q, ctrl_d;
    logic [15:0] baud_q, baud_d;
    logic        ovr_q, ovr_d, ferr_q, ferr_d, irq_q, irq_d;
    u32_t        dr_q, dr_d;

    tx_st_e      tx_st_q, tx_st_d;
    logic [9:0]  tx_sh_q, tx_sh_d;
    u4_t         tx_bit_q, tx_bit_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic        txen_q, txen_d;

    rx_st_e      rx_st_q, rx_st_d;
    logic        rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    u8_t         rx_sh_q, rx_sh_d;

    assign acc      = cs & rdy;
    assign rd_en    = acc & re;
    assign tx_push  = acc & we[0] & (adr == ADR_DATA);
    assign rx_pop   = rd_en & (adr == ADR_DATA);
    assign clr_ovr  = acc & we[0] & (adr == ADR_STAT) & dw[3];
    assign clr_ferr = acc & we[0] & (adr == ADR_STAT) & dw[4];
    assign tx_go    = (tx_st_q == TX_IDLE) & ~tx_empty & (~ctrl_q[2] | dsr);
    assign tx_pop   = tx_go;
    assign unused_ok = ^{dw[31:16], we[3:2], 1'(FIFO_DEPTH)};

    sio_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk(clk), .xreset(xreset), .push(tx_push), .din(dw[7:0]),
        .pop(tx_pop), .dout(tx_dout), .full(tx_full), .empty(tx_empty)
    );

    sio_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk(clk), .xreset(xreset), .push(rx_done), .din(rx_sh_q),
        .pop(rx_pop), .dout(rx_dout), .full(rx_full), .empty(rx_empty)
    );

    always_comb begin
        rdata = '0;
        unique case (adr)
            ADR_DATA: rdata = rx_empty ? '0 : {24'b0, rx_dout};
            ADR_STAT: rdata = {27'b0, ferr_q, ovr_q,
                               tx_empty & (tx_st_q == TX_IDLE),
                               tx_full, ~rx_empty};
            ADR_CTRL: rdata = {29'b0, ctrl_q};
            ADR_BAUD: rdata = {16'b0, baud_q};
            default:  rdata = '0;
        endcase
    end

    always_comb begin
        ctrl_d = ctrl_q;
        baud_d = baud_q;
        dr_d   = rd_en ? rdata : dr_q;
        if (acc && we[0] && adr == ADR_CTRL) ctrl_d = dw[2:0];
        if (acc && adr == ADR_BAUD) begin
            if (we[0]) baud_d[7:0]  = dw[7:0];
            if (we[1]) baud_d[15:8] = dw[15:8];
        end
        ovr_d  = (ovr_q & ~clr_ovr) | (rx_done & rx_full & ~rx_pop);
        ferr_d = (ferr_q & ~clr_ferr) | rx_ferr;
        irq_d  = (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & tx_empty);
    end

    // txd is the LSB of a shifter that idles at all-ones
    always_comb begin
        tx_st_d  = tx_st_q;
        tx_sh_d  = tx_sh_q;
        tx_bit_d = tx_bit_q;
        tx_cnt_d = tx_cnt_q;
        txen_d   = txen_q;
        unique case (tx_st_q)
            TX_IDLE: if (tx_go) begin
                tx_st_d  = TX_RUN;
                tx_sh_d  = {1'b1, tx_dout, 1'b0};
                tx_bit_d = '0;
                tx_cnt_d = baud_q;
                txen_d   = 1'b1;
            end
            TX_RUN: if (tx_cnt_q == '0) begin
                if (tx_bit_q == 4'd9) begin
                    tx_st_d = TX_IDLE;
                    tx_sh_d = '1;
                    txen_d  = 1'b0;
                end else begin
                    tx_bit_d = tx_bit_q + 1'b1;
                    tx_sh_d  = {1'b1, tx_sh_q[9:1]};
                    tx_cnt_d = baud_q;
                end
            end else begin
                tx_cnt_d = tx_cnt_q - 1'b1;
            end
            default: tx_st_d = TX_IDLE;
        endcase
    end

    always_comb begin
        rx_s1_d   = rxd;
        rx_s2_d   = rx_s1_q;
        rx_prev_d = rx_s2_q;
        rx_st_d   = rx_st_q;
        rx_cnt_d  = rx_cnt_q;
        rx_bit_d  = rx_bit_q;
        rx_sh_d   = rx_sh_q;
        rx_done   = 1'b0;
        rx_ferr   = 1'b0;
        unique case (rx_st_q)
            RX_IDLE: if (rx_prev_q && !rx_s2_q) begin
                rx_st_d  = RX_START;
                rx_cnt_d = baud_q >> 1;
            end
            RX_START: if (rx_cnt_q == '0) begin
                rx_st_d  = rx_s2_q ? RX_IDLE : RX_DATA;
                rx_cnt_d = baud_q;
                rx_bit_d = '0;
            end else begin
                rx_cnt_d = rx_cnt_q - 1'b1;
            end
            RX_DATA: if (rx_cnt_q == '0) begin
                rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                rx_cnt_d = baud_q;
                rx_bit_d = rx_bit_q + 1'b1;
                if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
            end else begin
                rx_cnt_d = rx_cnt_q - 1'b1;
            end
            RX_STOP: if (rx_cnt_q == '0) begin
                rx_st_d = RX_IDLE;
                rx_done = rx_s2_q;
                rx_ferr = ~rx_s2_q;
            end else begin
                rx_cnt_d = rx_cnt_q - 1'b1;
            end
            default: rx_st_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (xreset) begin
            ctrl_q    <= '0;
            baud_q    <= 16'(DIV_RST);
            ovr_q     <= 1'b0;
            ferr_q    <= 1'b0;
            irq_q     <= 1'b0;
            dr_q      <= '0;
            tx_st_q   <= TX_IDLE;
            tx_sh_q   <= '1;
            tx_bit_q  <= '0;
            tx_cnt_q  <= '0;
            txen_q    <= 1'b0;
            rx_st_q   <= RX_IDLE;
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            rx_cnt_q  <= '0;
            rx_bit_q  <= '0;
            rx_sh_q   <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            baud_q    <= baud_d;
            ovr_q     <= ovr_d;
            ferr_q    <= ferr_d;
            irq_q     <= irq_d;
            dr_q      <= dr_d;
            tx_st_q   <= tx_st_d;
            tx_sh_q   <= tx_sh_d;
            tx_bit_q  <= tx_bit_d;
            tx_cnt_q  <= tx_cnt_d;
            txen_q    <= txen_d;
            rx_st_q   <= rx_st_d;
            rx_s1_q   <= rx_s1_d;
            rx_s2_q   <= rx_s2_d;
            rx_prev_q <= rx_prev_d;
            rx_cnt_q  <= rx_cnt_d;
            rx_bit_q  <= rx_bit_d;
            rx_sh_q   <= rx_sh_d;
        end
    end

    assign dr   = dr_q;
    assign irq  = irq_q;
    assign txd  = tx_sh_q[0];
    assign txen = txen_q;
    assign dtr  = ~rx_full;

endmodule

// File: tb/tb_rv_sio.sv
// Directed self-checking bench for rv_sio (bit period 4 clocks after BAUD=3).
module tb_rv_sio;

`ifdef RV_SIO_FIFO_EN
    localparam int DEPTH = 16;
`else
    localparam int DEPTH = 1;
`endif

    localparam logic [4:0] A_DATA = 5'h00;
    localparam logic [4:0] A_STAT = 5'h04;
    localparam logic [4:0] A_CTRL = 5'h08;
    localparam logic [4:0] A_BAUD = 5'h0C;

    logic        clk = 1'b0;
    logic        xreset = 1'b1;
    logic [4:0]  adr = '0;
    logic        cs = 1'b0;
    logic        rdy = 1'b0;
    logic [3:0]  we = '0;
    logic        re = 1'b0;
    logic [31:0] dw = '0;
    logic [31:0] dr;
    logic        irq;
    logic        rxd = 1'b1;
    logic        txd;
    logic        dsr = 1'b1;
    logic        dtr;
    logic        txen;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rv_sio dut (
        .clk(clk), .xreset(xreset), .adr(adr), .cs(cs), .rdy(rdy),
        .we(we), .re(re), .dw(dw), .dr(dr), .irq(irq), .rxd(rxd),
        .txd(txd), .dsr(dsr), .dtr(dtr), .txen(txen)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [4:0] a, input logic [31:0] d,
                          input logic [3:0] w);
        adr = a; dw = d; we = w; cs = 1'b1; rdy = 1'b1;
        tick(1);
        cs = 1'b0; rdy = 1'b0; we = '0;
    endtask

    task automatic bus_rd(input logic [4:0] a, output logic [31:0] d);
        adr = a; re = 1'b1; cs = 1'b1; rdy = 1'b1;
        tick(1);
        cs = 1'b0; rdy = 1'b0; re = 1'b0;
        d = dr;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = f[i];
            tick(4);
        end
        rxd = 1'b1;
        tick(4);
    endtask

    task automatic wait_txen();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick(1);
            if (txen) ok = 1'b1;
        end
        chk("txen_rise", 32'(ok), 32'd1);
    endtask

    task automatic check_frame(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        tick(1);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) tick(4);
            chk($sformatf("tx_bit%0d", i), {30'b0, txen, txd}, {30'b0, 1'b1, f[i]});
        end
        tick(6);
        chk("txen_fall", 32'(txen), 32'd0);
    endtask

    logic [31:0] rd;

    initial begin
        tick(3);
        xreset = 1'b0;
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_txen", 32'(txen), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_dr", dr, 32'd0);
        chk("rst_dtr", 32'(dtr), 32'd1);
        bus_rd(A_STAT, rd); chk("rst_stat", rd, 32'h4);
        bus_rd(A_CTRL, rd); chk("rst_ctrl", rd, 32'h0);
        bus_rd(A_BAUD, rd); chk("rst_baud", rd, 32'd867);

        adr = A_CTRL; dw = 32'h7; we = 4'h1; cs = 1'b1; rdy = 1'b0;
        tick(1);
        cs = 1'b0; we = '0;
        bus_rd(A_CTRL, rd); chk("rdy_gate", rd, 32'h0);
        bus_rd(5'h10, rd); chk("unmapped", rd, 32'h0);

        bus_wr(A_BAUD, 32'h3, 4'h3);
        bus_rd(A_BAUD, rd); chk("baud_wr", rd, 32'h3);
        bus_wr(A_CTRL, 32'h0, 4'h1);
        chk("dr_hold", dr, 32'h3);

        bus_wr(A_DATA, 32'h55, 4'h1);
        wait_txen();
        check_frame(8'h55);
        bus_rd(A_STAT, rd); chk("tx_done_stat", rd, 32'h4);

        send_frame(8'hA3, 1'b1);
        bus_rd(A_STAT, rd); chk("rx_avail", rd, 32'h5);
        bus_rd(A_DATA, rd); chk("rx_a3", rd, 32'hA3);
        bus_rd(A_STAT, rd); chk("rx_drained", rd, 32'h4);

        send_frame(8'h3C, 1'b0);
        bus_rd(A_STAT, rd); chk("ferr_set", rd, 32'h14);
        bus_wr(A_STAT, 32'h10, 4'h1);
        bus_rd(A_STAT, rd); chk("ferr_clr", rd, 32'h4);

        for (int i = 0; i <= DEPTH; i++) send_frame(8'(8'h30 + i), 1'b1);
        chk("ovr_dtr", 32'(dtr), 32'd0);
        bus_rd(A_STAT, rd); chk("ovr_stat", rd, 32'hD);
        for (int i = 0; i < DEPTH; i++) begin
            bus_rd(A_DATA, rd);
            chk($sformatf("ovr_byte%0d", i), rd, 32'h30 + 32'(i));
        end
        bus_rd(A_STAT, rd); chk("ovr_sticky", rd, 32'hC);
        chk("dtr_back", 32'(dtr), 32'd1);
        bus_rd(A_DATA, rd); chk("rd_empty", rd, 32'h0);
        bus_wr(A_STAT, 32'h08, 4'h1);
        bus_rd(A_STAT, rd); chk("ovr_clr", rd, 32'h4);

        bus_wr(A_CTRL, 32'h4, 4'h1);
        dsr = 1'b0;
        bus_wr(A_DATA, 32'h41, 4'h1);
        tick(10);
        chk("flow_hold", {30'b0, txen, txd}, 32'h1);
        bus_rd(A_STAT, rd); chk("flow_stat", rd, (DEPTH == 1) ? 32'h2 : 32'h0);
        dsr = 1'b1;
        tick(1);
        chk("flow_start", {30'b0, txen, txd}, 32'h2);
        tick(45);
        bus_rd(A_STAT, rd); chk("flow_done", rd, 32'h4);

        bus_wr(A_CTRL, 32'h2, 4'h1);
        tick(1);
        chk("irq_tx_empty", 32'(irq), 32'd1);
        dsr = 1'b0;
        bus_wr(A_CTRL, 32'h6, 4'h1);
        bus_wr(A_DATA, 32'h7E, 4'h1);
        tick(2);
        chk("irq_tx_busy", 32'(irq), 32'd0);
        tick(5);
        chk("irq_tx_hold", 32'(irq), 32'd0);
        dsr = 1'b1;
        tick(3);
        chk("irq_tx_drain", 32'(irq), 32'd1);
        tick(45);

        bus_wr(A_CTRL, 32'h1, 4'h1);
        tick(2);
        chk("irq_rx_none", 32'(irq), 32'd0);
        send_frame(8'h5A, 1'b1);
        chk("irq_rx", 32'(irq), 32'd1);
        bus_rd(A_DATA, rd); chk("rx_5a", rd, 32'h5A);
        tick(2);
        chk("irq_rx_clr", 32'(irq), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rv_sio.md
RV_SIO -- requirements
Module: rv_sio

Interface
REQ-001 SHALL have parameter DIV_RST, default 867, reset value of the baud divisor; bit period = DIV+1 clk cycles.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, entries per TX and RX FIFO (power of two) when RV_SIO_FIFO_EN is defined.
REQ-003 SHALL have port clk  input  1  rising-edge system clock.
REQ-004 SHALL have port xreset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port adr  input  5  byte offset within the 32-byte register window.
REQ-006 SHALL have port cs  input  1  block select.
REQ-007 SHALL have port rdy  input  1  bus ready; an access takes effect only in a cycle with cs=1 and rdy=1.
REQ-008 SHALL have port we  input  4  byte-lane write enables.
REQ-009 SHALL have port re  input  1  read enable.
REQ-010 SHALL have port dw  input  32  write data.
REQ-011 SHALL have port dr  output  32  registered read data.
REQ-012 SHALL have port irq  output  1  level interrupt request.
REQ-013 SHALL have port rxd  input  1  serial receive line, asynchronous, idle high.
REQ-014 SHALL have port txd  output  1  serial transmit line, idle high.
REQ-015 SHALL have port dsr  input  1  peer-ready input for TX flow control.
REQ-016 SHALL have port dtr  output  1  high while the RX buffer can accept a byte.
REQ-017 SHALL have port txen  output  1  high from the start bit through the stop bit of each transmitted frame.

Function
REQ-018 Register map: 0x00 DATA (wr: push dw[7:0] to TX, needs we[0]; rd: pop RX byte into dr[7:0]); 0x04 STATUS; 0x08 CTRL; 0x0C BAUD (dw[15:0], lanes we[0]/we[1]); other offsets read 0, writes ignored.
REQ-019 STATUS bits: [0] rx_avail, [1] tx_full, [2] tx_idle (TX buffer empty and shifter idle), [3] overrun (sticky), [4] frame_err (sticky); writing 1 to bit 3 or 4 with we[0] clears that bit.
REQ-020 CTRL bits: [0] rx_ie, [1] tx_ie, [2] flow_en; all 0 after reset.
REQ-021 dr SHALL be registered: read data of the access cycle appears in the following cycle and holds until the next read.
REQ-022 Frame format 8N1: start 0, 8 data bits LSB first, stop 1; each bit held DIV+1 cycles.
REQ-023 TX SHALL start a frame the cycle after the TX buffer is non-empty and the shifter is idle, gated additionally by dsr=1 when flow_en=1.
REQ-024 Write to DATA while tx_full SHALL be discarded.
REQ-025 RX SHALL use a 2-flop synchronizer, detect start on a falling edge, re-check low at half bit (else abort), sample data at bit centres.
REQ-026 Stop bit sampled 0 SHALL set frame_err and discard the byte.
REQ-027 Byte completed while RX buffer full SHALL be discarded and set overrun.
REQ-028 Read of DATA while RX empty SHALL return 0 and not change state; simultaneous push and pop SHALL both take effect.
REQ-029 irq SHALL be registered: (rx_ie & rx_avail) | (tx_ie & TX buffer empty).
REQ-030 dtr SHALL be 1 whenever the RX buffer is not full.
REQ-031 Writing BAUD SHALL take effect at the next bit boundary.

Reset
REQ-032 On xreset: txd=1, txen=0, irq=0, dr=0, FIFOs empty, STATUS sticky bits 0, CTRL=0, BAUD=DIV_RST, both FSMs IDLE; reset mid-frame aborts immediately.

Configuration
REQ-033 With RV_SIO_FIFO_EN defined, TX and RX buffers SHALL be FIFO_DEPTH-entry FIFOs; without it, each SHALL be a single-byte holding register (tx_full = holding register occupied).

Structure
REQ-034 Shared package rv_types SHALL hold u4_t, u8_t, u32_t and the register offset constants.
REQ-035 A sub-module sio_fifo (synchronous FIFO with full/empty) SHALL be instantiated for TX and RX.

Verification
REQ-036 Reset, BAUD=3, write 0x55 to DATA -> txen rises, txd emits 0,1,0,1,0,1,0,1,0,1 at 4 cycles per bit, then STATUS[2]=1.
REQ-037 rxd drives frame 0xA3 at BAUD=3 -> STATUS[0]=1; read DATA -> dr=0x000000A3 one cycle later, STATUS[0]=0.
REQ-038 rxd frame with stop bit 0 -> STATUS[4]=1, no byte queued; write 0x10 to STATUS -> bit cleared.
REQ-039 Receive FIFO_DEPTH+1 bytes (depth 1 without macro) without reading -> STATUS[3]=1, dtr=0, first bytes intact.
REQ-040 CTRL=0x04, dsr=0, write 0x41 -> txd stays 1; dsr=1 -> frame starts next cycle.
REQ-041 CTRL=0x02 with TX empty -> irq=1; write DATA -> irq=0 until buffer drains.
